hi_lo_unit: RTL

- Consumer side of the ALU's 64-bit result path: owns the HI/LO architectural registers.
- Supported operations: writing the ALU's {ALUResultHi, ALUResult} product into HI/LO; accumulate and subtract (madd/msub); mthi and mtlo moves.
- Runs iterative signed and unsigned 32-cycle division.
- Sits beside ALU32Bit in EX. Controller issues Start/Op and stalls on Busy; mfhi/mflo read Hi/Lo directly.

---
 rtl/hi_lo_pkg.sv | 24 ++
 rtl/hi_lo_unit_if.sv | 20 ++
 rtl/hi_lo_unit_div_iter.sv | 45 ++++
 rtl/hi_lo_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/hi_lo_pkg.sv
// Shared op codes, FSM states and counter sizing for the HI/LO unit.
package hi_lo_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MTHI = 4'd1;
  localparam logic [3:0] OP_MTLO = 4'd2;
  localparam logic [3:0] OP_MULW = 4'd3;
  localparam logic [3:0] OP_MADD = 4'd4;
  localparam logic [3:0] OP_MSUB = 4'd5;
  localparam logic [3:0] OP_DIV  = 4'd6;
  localparam logic [3:0] OP_DIVU = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/hi_lo_unit_if.sv
// Request/result bundle between the EX-stage controller and the HI/LO unit.
interface hi_lo_unit_if import hi_lo_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ProdHi;
  logic [WIDTH-1:0] ProdLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output Start, Op, A, B, ProdHi, ProdLo,
                  input  Busy, Done, Hi, Lo);
  modport slave  (input  Start, Op, A, B, ProdHi, ProdLo,
                  output Busy, Done, Hi, Lo);
endinterface

// File: rtl/hi_lo_unit_div_iter.sv
// Unsigned restoring divider datapath: one shift-subtract per step pulse.
module div_iter import hi_lo_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    trial = {remainder, quotient[WIDTH-1]};
    diff  = trial - {1'b0, dsr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dsr       <= divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        remainder <= diff[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hi_lo_unit.sv
// HI/LO architectural registers: moves, product write/accumulate, iterative divide.
module hi_lo_unit import hi_lo_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic         Clk,
  input logic         Reset,
  hi_lo_unit_if.slave bus
);

  localparam int unsigned      CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             accept, is_div, div_zero, div_load, div_step;
  logic             a_neg, b_neg, neg_q, neg_r;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic [2*WIDTH-1:0] prod, acc_sum, acc_diff;

  assign bus.Busy = (state != S_IDLE);
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

  always_comb begin
    accept   = bus.Start && (state == S_IDLE);
    is_div   = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
    div_zero = (bus.B == '0);
    a_neg    = (bus.Op == OP_DIV) && bus.A[WIDTH-1];
    b_neg    = (bus.Op == OP_DIV) && bus.B[WIDTH-1];
    a_mag    = a_neg ? -bus.A : bus.A;
    b_mag    = b_neg ? -bus.B : bus.B;
    div_load = accept && is_div && !div_zero;
    div_step = (state == S_RUN) && (cnt != CNT_LAST);
    prod     = {bus.ProdHi, bus.ProdLo};
    acc_sum  = {hi_q, lo_q} + prod;
    acc_diff = {hi_q, lo_q} - prod;

    state_next = state;
    case (state)
      S_IDLE:  if (div_load) state_next = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (div_load) begin
      cnt   <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end else if (div_step) begin
      cnt <= cnt + CW'(1);
    end
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (Clk),
    .rst       (Reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Divide-by-zero completes in the accept cycle, so only a real divide defers Done.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_FIX) begin
        lo_q   <= neg_q ? -quo : quo;
        hi_q   <= neg_r ? -rem : rem;
        done_q <= 1'b1;
      end else if (accept) begin
        done_q <= !div_load;
        case (bus.Op)
          OP_MTHI: hi_q <= bus.A;
          OP_MTLO: lo_q <= bus.A;
          OP_MULW: {hi_q, lo_q} <= prod;
          OP_MADD: {hi_q, lo_q} <= acc_sum;
          OP_MSUB: {hi_q, lo_q} <= acc_diff;
          OP_DIV, OP_DIVU: begin
            if (div_zero) begin
              lo_q <= '1;
              hi_q <= bus.A;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
